// File: rtl/m_port_pkg.sv
// m_port_pkg: shared FSM state encoding, bus mode constants and default widths
// for the bit-serial bus master m_port.
package m_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    WDATA,
    WAIT_ACK,
    RDATA
  } state_t;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_DATA = 1'b1;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/m_port_deser.sv
// m_port_deser: LSB-first read deserialiser with sticky ack; flags completion once
// DATA_W bits and an ack have both been seen, in either order.
module m_port_deser
  import m_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic              i_bit,
  input  logic              i_bitValid,
  input  logic              i_ack,
  output logic [DATA_W-1:0] o_data,
  output logic              o_complete
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ackSeen;
  logic              r_full;
  logic              w_take;
  logic              w_lastBit;

  assign w_take    = i_enable && i_bitValid && !r_full;
  assign w_lastBit = w_take && (r_cnt == LAST);

  // Shifting in from the top leaves the first received bit in position 0 once full.
  assign o_data     = w_take ? {i_bit, r_shift[DATA_W-1:1]} : r_shift;
  assign o_complete = i_enable && (r_full || w_lastBit) && (r_ackSeen || i_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_ackSeen <= 1'b0;
      r_full    <= 1'b0;
    end else if (i_clear) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_ackSeen <= 1'b0;
      r_full    <= 1'b0;
    end else if (i_enable) begin
      if (w_take) begin
        r_shift <= o_data;
        if (w_lastBit) r_full <= 1'b1;
        else           r_cnt  <= r_cnt + 1'b1;
      end
      if (i_ack) r_ackSeen <= 1'b1;
    end
  end

endmodule

// File: rtl/m_port.sv
// m_port: bit-serial bus master. Writes send address, one gap cycle, data, then wait
// for ack; reads send address then collect the reply. Optional M_PORT_TIMEOUT_EN.
module m_port
  import m_port_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_req,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic              m_rw,
  output logic              m_ready,
  output logic              m_done,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_rdata_valid,
  output logic              m_timeout,
  output logic              bus_data_out,
  output logic              bus_data_out_valid,
  output logic              bus_mode,
  output logic              bus_rw,
  input  logic              bus_data_in,
  input  logic              bus_data_in_valid,
  input  logic              bus_s_ack,
  input  logic              bus_s_ready
);

  localparam int               MAX_W     = maxOf(ADDR_W, DATA_W);
  localparam int               CNT_W     = $clog2(MAX_W) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [ADDR_W-1:0] r_addrSh;
  logic [DATA_W-1:0] r_wdataSh;
  logic              w_deserClear;
  logic              w_deserEnable;
  logic              w_deserDone;
  logic [DATA_W-1:0] w_deserData;

`ifdef M_PORT_TIMEOUT_EN
  localparam int              TO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  logic [TO_W-1:0] r_toCnt;
`else
  // ACK_TIMEOUT is never negative, so this keeps the abort pulse permanently low.
  assign m_timeout = (ACK_TIMEOUT < 0);
`endif

  assign m_ready       = (r_state == IDLE);
  assign w_deserClear  = (r_state == ADDR) && (r_bitCnt == ADDR_LAST) && !bus_rw;
  assign w_deserEnable = (r_state == RDATA);

  m_port_deser #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_deserClear),
    .i_enable   (w_deserEnable),
    .i_bit      (bus_data_in),
    .i_bitValid (bus_data_in_valid),
    .i_ack      (bus_s_ack),
    .o_data     (w_deserData),
    .o_complete (w_deserDone)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= IDLE;
      r_bitCnt           <= '0;
      r_addrSh           <= '0;
      r_wdataSh          <= '0;
      bus_data_out       <= 1'b0;
      bus_data_out_valid <= 1'b0;
      bus_mode           <= MODE_ADDR;
      bus_rw             <= 1'b0;
      m_done             <= 1'b0;
      m_rdata            <= '0;
      m_rdata_valid      <= 1'b0;
`ifdef M_PORT_TIMEOUT_EN
      m_timeout          <= 1'b0;
      r_toCnt            <= '0;
`endif
    end else begin
      m_done        <= 1'b0;
      m_rdata_valid <= 1'b0;
`ifdef M_PORT_TIMEOUT_EN
      m_timeout     <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          // Bit 0 is registered on the accepting edge so it is on the bus the next cycle.
          if (m_req && bus_s_ready) begin
            r_state            <= ADDR;
            bus_rw             <= m_rw;
            r_wdataSh          <= m_wdata;
            r_addrSh           <= m_addr >> 1;
            bus_data_out       <= m_addr[0];
            bus_data_out_valid <= 1'b1;
            bus_mode           <= MODE_ADDR;
            r_bitCnt           <= '0;
          end
        end
        ADDR: begin
          if (r_bitCnt == ADDR_LAST) begin
            r_bitCnt           <= '0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            if (bus_rw) begin
              r_state  <= GAP;
              bus_mode <= MODE_ADDR;
            end else begin
              r_state  <= RDATA;
              bus_mode <= MODE_DATA;
`ifdef M_PORT_TIMEOUT_EN
              r_toCnt  <= '0;
`endif
            end
          end else begin
            r_bitCnt     <= r_bitCnt + 1'b1;
            bus_data_out <= r_addrSh[0];
            r_addrSh     <= r_addrSh >> 1;
          end
        end
        GAP: begin
          r_state            <= WDATA;
          r_bitCnt           <= '0;
          bus_data_out       <= r_wdataSh[0];
          r_wdataSh          <= r_wdataSh >> 1;
          bus_data_out_valid <= 1'b1;
          bus_mode           <= MODE_DATA;
        end
        WDATA: begin
          if (r_bitCnt == DATA_LAST) begin
            r_state            <= WAIT_ACK;
            r_bitCnt           <= '0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
`ifdef M_PORT_TIMEOUT_EN
            r_toCnt            <= '0;
`endif
          end else begin
            r_bitCnt     <= r_bitCnt + 1'b1;
            bus_data_out <= r_wdataSh[0];
            r_wdataSh    <= r_wdataSh >> 1;
          end
        end
        WAIT_ACK: begin
          if (bus_s_ack) begin
            m_done   <= 1'b1;
            r_state  <= IDLE;
            bus_mode <= MODE_ADDR;
          end
`ifdef M_PORT_TIMEOUT_EN
          else if (r_toCnt == TO_LAST) begin
            m_timeout <= 1'b1;
            r_state   <= IDLE;
            bus_mode  <= MODE_ADDR;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
`endif
        end
        RDATA: begin
          // Completion beats a timeout that would expire on the same edge.
          if (w_deserDone) begin
            m_rdata       <= w_deserData;
            m_rdata_valid <= 1'b1;
            m_done        <= 1'b1;
            r_state       <= IDLE;
            bus_mode      <= MODE_ADDR;
          end
`ifdef M_PORT_TIMEOUT_EN
          else if (r_toCnt == TO_LAST) begin
            m_timeout <= 1'b1;
            r_state   <= IDLE;
            bus_mode  <= MODE_ADDR;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
